// File: rtl/btn_event_ctrl.sv
// Button event controller: edge detect, per-button PRESS/RELEASE/LONG FSMs and round-robin
// enqueue into an event FIFO. Define BTN_AUTOREPEAT_EN to add the REPEAT state.
module btn_event_ctrl #(
   parameter int CLKIN_FREQ    = 27_000_000,
   parameter int NUM_BTNS      = 4,
   parameter int LONG_PRESS_MS = 500,
   parameter int REPEAT_MS     = 100,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_BTNS-1:0]         btnLevel,
   output logic                        evtValid,
   input  logic                        evtReady,
   output logic [1:0]                  evtCode,
   output logic [$clog2(NUM_BTNS)-1:0] evtBtn,
   output logic                        overflow
);
   localparam int TICK_DIV = CLKIN_FREQ / 1000;
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW       = $clog2(NUM_BTNS);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX  = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
   localparam int CW       = $clog2(CNT_MAX + 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PRESSED  = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;
   localparam logic [1:0] EVT_PRESS   = 2'd0;
   localparam logic [1:0] EVT_RELEASE = 2'd1;
   localparam logic [1:0] EVT_LONG    = 2'd2;
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [1:0] ST_REPEAT   = 2'd3;
   localparam logic [1:0] EVT_REPEAT  = 2'd3;
`endif

   logic [PW-1:0]       presc_q, presc_d;
   logic                tick;
   logic [NUM_BTNS-1:0] smp_q, smp_d, prev_q, prev_d, press, rel;
   logic [1:0]          state_q [NUM_BTNS];
   logic [1:0]          state_d [NUM_BTNS];
   logic [CW-1:0]       cnt_q [NUM_BTNS];
   logic [CW-1:0]       cnt_d [NUM_BTNS];
   logic [NUM_BTNS-1:0] new_evt;
   logic [1:0]          new_code [NUM_BTNS];
   logic [NUM_BTNS-1:0] pend_vld_q, pend_vld_d;
   logic [1:0]          pend_code_q [NUM_BTNS];
   logic [1:0]          pend_code_d [NUM_BTNS];
   logic [BW-1:0]       rr_q, rr_d, sel, cand;
   logic                grant, served;
   logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
   logic [BW+1:0]       mem_q [FIFO_DEPTH];
   logic [BW+1:0]       wdata, head;
   logic                full, empty, push, pop, drop;
   logic                overflow_q, overflow_d;

   // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
   always_comb begin
      tick    = (presc_q == PW'(TICK_DIV - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
      smp_d   = btnLevel;
      prev_d  = smp_q;
      press   = prev_q & ~smp_q;
      rel     = ~prev_q & smp_q;
   end

   always_comb begin
      for (int i = 0; i < NUM_BTNS; i++) begin
         state_d[i]  = state_q[i];
         cnt_d[i]    = cnt_q[i];
         new_evt[i]  = 1'b0;
         new_code[i] = EVT_PRESS;
         if (rel[i] && (state_q[i] != ST_IDLE)) begin
            state_d[i]  = ST_IDLE;
            cnt_d[i]    = '0;
            new_evt[i]  = 1'b1;
            new_code[i] = EVT_RELEASE;
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  if (press[i]) begin
                     state_d[i]  = ST_PRESSED;
                     cnt_d[i]    = '0;
                     new_evt[i]  = 1'b1;
                     new_code[i] = EVT_PRESS;
                  end
               end
               ST_PRESSED: begin
                  if (tick) begin
                     if (cnt_q[i] + 1'b1 == CW'(LONG_PRESS_MS)) begin
                        state_d[i]  = ST_HELD;
                        cnt_d[i]    = '0;
                        new_evt[i]  = 1'b1;
                        new_code[i] = EVT_LONG;
                     end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                     end
                  end
               end
               ST_HELD: begin
`ifdef BTN_AUTOREPEAT_EN
                  if (tick) begin
                     state_d[i] = ST_REPEAT;
                     cnt_d[i]   = '0;
                  end
`endif
               end
`ifdef BTN_AUTOREPEAT_EN
               ST_REPEAT: begin
                  if (tick) begin
                     if (cnt_q[i] + 1'b1 == CW'(REPEAT_MS)) begin
                        cnt_d[i]    = '0;
                        new_evt[i]  = 1'b1;
                        new_code[i] = EVT_REPEAT;
                     end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                     end
                  end
               end
`endif
               default: state_d[i] = ST_IDLE;
            endcase
         end
      end
   end

   // Round-robin pick starting at rr_q, then FIFO push/pop and pending-slot update.
   always_comb begin
      int idx;
      idx   = 0;
      cand  = '0;
      grant = 1'b0;
      sel   = '0;
      for (int k = 0; k < NUM_BTNS; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_BTNS) idx = idx - NUM_BTNS;
         cand = BW'(idx);
         if (!grant && pend_vld_q[cand]) begin
            grant = 1'b1;
            sel   = cand;
         end
      end
      empty      = (wr_q == rd_q);
      full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop        = !empty && evtReady;
      push       = grant && (!full || pop);
      drop       = grant && full && !pop;
      wdata      = {pend_code_q[sel], sel};
      wr_d       = push ? wr_q + 1'b1 : wr_q;
      rd_d       = pop ? rd_q + 1'b1 : rd_q;
      rr_d       = rr_q;
      if (grant) rr_d = (sel == BW'(NUM_BTNS - 1)) ? '0 : sel + 1'b1;
      overflow_d = overflow_q | drop;
      served     = 1'b0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         pend_vld_d[i]  = pend_vld_q[i];
         pend_code_d[i] = pend_code_q[i];
         served         = grant && (sel == BW'(i));
         if (served) pend_vld_d[i] = 1'b0;
         if (new_evt[i]) begin
            if (pend_vld_q[i] && !served) overflow_d = 1'b1;
            pend_vld_d[i]  = 1'b1;
            pend_code_d[i] = new_code[i];
         end
      end
      head              = mem_q[rd_q[AW-1:0]];
      evtValid          = !empty;
      {evtCode, evtBtn} = empty ? '0 : head;
      overflow          = overflow_q;
   end

   // NOTE: state flops use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q    <= '0;
         smp_q      <= '1;
         prev_q     <= '1;
         pend_vld_q <= '0;
         rr_q       <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < NUM_BTNS; i++) begin
            state_q[i]     <= ST_IDLE;
            cnt_q[i]       <= '0;
            pend_code_q[i] <= EVT_PRESS;
         end
      end else begin
         presc_q    <= presc_d;
         smp_q      <= smp_d;
         prev_q     <= prev_d;
         pend_vld_q <= pend_vld_d;
         rr_q       <= rr_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         overflow_q <= overflow_d;
         for (int i = 0; i < NUM_BTNS; i++) begin
            state_q[i]     <= state_d[i];
            cnt_q[i]       <= cnt_d[i];
            pend_code_q[i] <= pend_code_d[i];
         end
      end
   end

   // NOTE: FIFO storage is not reset; the empty flag gates everything read out of it.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 SHALL have parameter CLKIN_FREQ, default 27_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter NUM_BTNS, default 4, number of button inputs (2..8).
REQ-003 SHALL have parameter LONG_PRESS_MS, default 500, hold time in ms before a LONG event.
REQ-004 SHALL have parameter REPEAT_MS, default 100, auto-repeat interval in ms.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of 2).
REQ-006 SHALL have port clk  input  1  system clock, the only clock.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port btnLevel  input  NUM_BTNS  debounced levels, active-low (1 = released).
REQ-009 SHALL have port evtValid  output  1  FIFO head holds an event.
REQ-010 SHALL have port evtReady  input  1  consumer accepts the head event.
REQ-011 SHALL have port evtCode  output  2  event type: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
REQ-012 SHALL have port evtBtn  output  $clog2(NUM_BTNS)  button index of the head event.
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-014 SHALL generate a 1 ms tick: one-cycle pulse every CLKIN_FREQ/1000 clk cycles, free-running after reset.
REQ-015 SHALL register btnLevel once and detect edges against the previous registered sample; 1->0 = press, 0->1 = release.
REQ-016 SHALL run one FSM per button: IDLE, PRESSED, HELD, plus REPEAT when REQ-031 applies.
REQ-017 SHALL transition IDLE->PRESSED on press, raise a PRESS pending, and clear that button's ms counter.
REQ-018 SHALL count ticks in PRESSED; at count == LONG_PRESS_MS, go to HELD, raise a LONG pending, and clear the counter.
REQ-019 SHALL return any non-IDLE state to IDLE on release and raise a RELEASE pending; release takes priority over a same-cycle LONG/REPEAT.
REQ-020 SHALL keep one pending slot per button; a new event overwrites an unserved pending event and sets overflow.
REQ-021 SHALL enqueue at most one pending event per cycle, round-robin starting at the index after the last served button.
REQ-022 SHALL drop the selected event and set overflow when the FIFO is full and no pop occurs that cycle; push and pop in the same cycle when full SHALL succeed.
REQ-023 SHALL pop the FIFO head when evtValid && evtReady; evtCode/evtBtn SHALL hold stable while evtValid && !evtReady.
REQ-024 SHALL assert evtValid exactly 3 clk after a btnLevel edge when the FIFO is empty and no other event is pending (sample, detect/pending, enqueue).
REQ-025 SHALL keep FIFO pointers one bit wider than log2(FIFO_DEPTH); full/empty SHALL be decided by the MSB compare, with wrap-around.
REQ-026 SHALL keep overflow at 1 until reset.

Reset
REQ-027 SHALL, on reset, force all FSMs to IDLE, clear all counters, pending slots, FIFO pointers and the tick prescaler, and set the round-robin pointer to 0.
REQ-028 SHALL drive evtValid=0, evtCode=0, evtBtn=0, overflow=0 during and after reset.
REQ-029 SHALL load the previous-sample registers with 1, so a button held through reset yields PRESS after reset release.
REQ-030 SHALL abort reset mid-operation without emitting RELEASE for held buttons and SHALL discard queued events.

Configuration
REQ-031 SHALL, with BTN_AUTOREPEAT_EN defined, go HELD->REPEAT at the first tick and then raise a REPEAT pending every REPEAT_MS ticks while the button remains pressed.
REQ-032 SHALL, without BTN_AUTOREPEAT_EN, omit the REPEAT state and counter logic, remain in HELD until release, and never emit evtCode 3.

Verification (CLKIN_FREQ=10_000, NUM_BTNS=4, LONG_PRESS_MS=5, REPEAT_MS=2, FIFO_DEPTH=4)
REQ-033 SHALL cover: btnLevel[2] 1->0 with evtReady=1 -> evtValid 3 cycles later, evtCode=0, evtBtn=2, popped same cycle.
REQ-034 SHALL cover: btn 0 held 80 cycles, BTN_AUTOREPEAT_EN on -> PRESS, LONG at ~50 cycles, then REPEAT every 20 cycles, then RELEASE on release.
REQ-035 SHALL cover: btns 0 and 3 pressed in the same cycle -> two PRESS events, btn 0 then btn 3, on consecutive cycles.
REQ-036 SHALL cover: evtReady=0 with 5 events generated -> 4 queued, overflow=1, head stable; push+pop when full does not set overflow.
REQ-037 SHALL cover: reset asserted with btn 1 held and 2 events queued -> evtValid=0, overflow=0; PRESS for btn 1 appears 3 cycles after reset release.
